seg_display_scanner: RTL and testbench

//   Drives the board's multiplexed 6-digit 7-segment display (Segment/Digital) for the

---
 rtl/seg_display_scanner.sv | 166 ++++++++++++++++
 tb/tb_seg_display_scanner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// Multiplexed N-digit 7-segment display scanner with double-buffered display data.
// One digit is lit per slot. Each slot starts with a blank gap to prevent ghosting.
module seg_display_scanner #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned GAP_CYCLES = 500
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      WrEn,
    input  logic [4*NUM_DIGITS-1:0]   WrData,
    input  logic [NUM_DIGITS-1:0]     DpMask,
    input  logic [NUM_DIGITS-1:0]     BlankMask,
    output logic [7:0]                Segment,
    output logic [NUM_DIGITS-1:0]     Digital,
    output logic                      FrameDone
);

    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_W-1:0]       pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic [DATA_W-1:0]       act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    frame_done_q, frame_done_d;

    logic                    cnt_wrap_c;
    logic                    frame_end_c;
    logic [3:0]              nib_c;
    logic                    dp_sel_c;
    logic                    blank_sel_c;

    // Active-high g..a segment pattern for a hex nibble
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] p;
        case (h)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Select the current digit's nibble and mask bits from the active buffer
    always_comb begin
        nib_c       = 4'h0;
        dp_sel_c    = 1'b0;
        blank_sel_c = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (IDX_W'(i) == idx_q) begin
                nib_c       = act_data_q[4*i +: 4];
                dp_sel_c    = act_dp_q[i];
                blank_sel_c = act_blank_q[i];
            end
        end
    end

    always_comb begin
        cnt_wrap_c   = (cnt_q == CNT_W'(SCAN_DIV - 1));
        frame_end_c  = cnt_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        seg_d        = 8'hFF;
        dig_d        = '1;
        frame_done_d = 1'b0;

        if (cnt_wrap_c) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        case (state_q)
            GAP:   if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = DRIVE;
            DRIVE: if (cnt_wrap_c)                      state_d = GAP;
        endcase

        if (WrEn) begin
            pend_data_d  = WrData;
            pend_dp_d    = DpMask;
            pend_blank_d = BlankMask;
        end

        // A write on the boundary cycle bypasses pending so it shows this frame
        if (frame_end_c) begin
            act_data_d   = WrEn ? WrData    : pend_data_q;
            act_dp_d     = WrEn ? DpMask    : pend_dp_q;
            act_blank_d  = WrEn ? BlankMask : pend_blank_q;
            frame_done_d = 1'b1;
        end

        if (state_q == DRIVE) begin
            dig_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = blank_sel_c ? 8'hFF : ~{dp_sel_c, hex_to_seg(nib_c)};
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= GAP;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            seg_q        <= 8'hFF;
            dig_q        <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Segment   = seg_q;
    assign Digital   = dig_q;
    assign FrameDone = frame_done_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: directed and random writes checked cycle by cycle
// against a frame-position model of the display.
module tb_seg_display_scanner;

    localparam int ND    = 6;
    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int FRAME = ND * DIV;

    logic            Clock;
    logic            Reset;
    logic            WrEn;
    logic [23:0]     WrData;
    logic [5:0]      DpMask;
    logic [5:0]      BlankMask;
    logic [7:0]      Segment;
    logic [5:0]      Digital;
    logic            FrameDone;

    seg_display_scanner #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (DIV),
        .GAP_CYCLES (GAP)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .WrEn      (WrEn),
        .WrData    (WrData),
        .DpMask    (DpMask),
        .BlankMask (BlankMask),
        .Segment   (Segment),
        .Digital   (Digital),
        .FrameDone (FrameDone)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: position in frame plus the two display buffers
    int          m_pos;
    logic [23:0] m_data, p_data;
    logic [5:0]  m_dp, p_dp, m_bl, p_bl;
    logic [7:0]  e_seg;
    logic [5:0]  e_dig;
    logic        e_fd;
    int          lit [ND];
    int          fd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_data = '0; m_dp = '0; m_bl = 6'h3F;
        p_data = '0; p_dp = '0; p_bl = 6'h3F;
        e_seg  = 8'hFF; e_dig = 6'h3F; e_fd = 1'b0;
    endtask

    // Called at a falling edge: check outputs, apply inputs, advance model one clock
    task automatic step(input logic wr, input logic [23:0] d, input logic [5:0] dp,
                        input logic [5:0] bl);
        int slot, dg;
        logic [3:0] nib;
        chk("segment", 32'(Segment), 32'(e_seg));
        chk("digital", 32'(Digital), 32'(e_dig));
        chk("framedone", 32'(FrameDone), 32'(e_fd));
        chk("onehot", 32'($countones(~Digital) <= 1), 32'd1);
        for (int k = 0; k < ND; k++) if (!Digital[k]) lit[k]++;
        if (FrameDone) fd_seen++;

        WrEn = wr; WrData = d; DpMask = dp; BlankMask = bl;

        slot = m_pos % DIV;
        dg   = m_pos / DIV;
        if (slot < GAP) begin
            e_seg = 8'hFF;
            e_dig = 6'h3F;
        end else begin
            nib   = 4'(m_data >> (4 * dg));
            e_dig = 6'h3F & ~(6'd1 << dg);
            e_seg = m_bl[dg] ? 8'hFF : ~{m_dp[dg], seg_tbl[nib]};
        end
        e_fd = (m_pos == FRAME - 1);
        if (m_pos == FRAME - 1) begin
            m_data = wr ? d  : p_data;
            m_dp   = wr ? dp : p_dp;
            m_bl   = wr ? bl : p_bl;
        end
        if (wr) begin
            p_data = d; p_dp = dp; p_bl = bl;
        end
        m_pos = (m_pos + 1) % FRAME;
        @(negedge Clock);
    endtask

    task automatic idle();
        step(1'b0, 24'h0, 6'h0, 6'h0);
    endtask

    task automatic run_to(input int p);
        int guard = 0;
        while (m_pos != p && guard < 2 * FRAME) begin
            idle();
            guard++;
        end
        chk("run_to_bound", 32'(m_pos), 32'(p));
    endtask

    initial begin
        Reset = 1'b0; WrEn = 1'b0; WrData = '0; DpMask = '0; BlankMask = '0;
        model_reset();
        fd_seen = 0;
        for (int k = 0; k < ND; k++) lit[k] = 0;
        @(negedge Clock);
        @(negedge Clock);
        chk("rst_segment", 32'(Segment), 32'hFF);
        chk("rst_digital", 32'(Digital), 32'h3F);
        chk("rst_framedone", 32'(FrameDone), 32'h0);
        Reset = 1'b1;

        // Dark display, three frames
        repeat (3 * FRAME + 1) idle();
        chk("fd_3frames", 32'(fd_seen), 32'd3);

        // First write: 0123AF, no DP, no blank
        run_to(0);
        step(1'b1, 24'h0123AF, 6'h00, 6'h00);
        run_to(0);
        run_to(4);
        chk("d0_F_seg", 32'(Segment), 32'h8E);
        chk("d0_F_dig", 32'(Digital), 32'h3E);
        run_to(44);
        chk("d5_0_seg", 32'(Segment), 32'hC0);
        chk("d5_0_dig", 32'(Digital), 32'h1F);
        run_to(0);
        for (int k = 0; k < ND; k++) lit[k] = 0;
        repeat (FRAME) idle();
        for (int k = 0; k < ND; k++) chk("lit_cycles", 32'(lit[k]), 32'd6);

        // DP on digit 2, blank digit 5
        step(1'b1, 24'h0123AF, 6'b000100, 6'b100000);
        run_to(0);
        run_to(4);
        chk("d0_keep_seg", 32'(Segment), 32'h8E);
        run_to(21);
        chk("d2_dp_seg", 32'(Segment), 32'h30);
        chk("d2_dp_bit7", 32'(Segment[7]), 32'h0);
        run_to(44);
        chk("d5_blank_seg", 32'(Segment), 32'hFF);
        chk("d5_blank_dig", 32'(Digital), 32'h1F);

        // Mid-frame write must not tear the current frame
        run_to(28);
        step(1'b1, 24'h456789, 6'h00, 6'h00);
        run_to(37);
        chk("d4_old_seg", 32'(Segment), 32'hF9);
        run_to(44);
        chk("d5_old_seg", 32'(Segment), 32'hFF);
        run_to(0);
        run_to(4);
        chk("d0_new_seg", 32'(Segment), 32'h90);

        // Write on the boundary cycle shows in the very next frame
        run_to(FRAME - 1);
        step(1'b1, 24'hABCDE8, 6'h00, 6'h00);
        run_to(4);
        chk("d0_bnd_seg", 32'(Segment), 32'h80);

        // Random writes over ten frames
        repeat (10 * FRAME) begin
            step(($urandom_range(0, 7) == 0), 24'($urandom()), 6'($urandom()),
                 6'($urandom()) & 6'($urandom()));
        end

        // Asynchronous reset during digit 2 drive
        run_to(21);
        chk("pre_rst_dig", 32'(Digital), 32'h3B);
        Reset = 1'b0;
        #1;
        chk("async_rst_seg", 32'(Segment), 32'hFF);
        chk("async_rst_dig", 32'(Digital), 32'h3F);
        chk("async_rst_fd", 32'(FrameDone), 32'h0);
        model_reset();
        WrEn = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (FRAME + 12) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
